music_box_sequencer: RTL and testbench
======================================

Name: music_box_sequencer

Overview:
- Playback controller for the music box: walks a song's note table in the note ROM, times each note from a per-entry duration field, and drives the tone generator's note code and enable.
- Supports play/pause/stop, song select, inter-note articulation gap and end-of-song looping.
- Sits between the user-button debouncers, the synchronous note ROM and the tone generator.

Parameters:
TICKS_PER_UNIT, 1500000, clk cycles per duration unit (24-bit counter range)
GAP_TICKS, 120000, silent cycles at the end of every note; 0 disables the gap; must be < TICKS_PER_UNIT
LOOP, 1, 1 = restart the song at the end marker; 0 = stop and pulse song_done

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
play  in  1  one-cycle pulse: start from IDLE, pause from PLAY/GAP, resume from PAUSED
stop  in  1  one-cycle pulse: abort to IDLE
song_sel  in  2  song select, sampled only on start
rom_addr  out  7  note ROM address {song_q, idx}
rom_data  in  8  ROM word: [7:5] duration units, [4:0] note code (0 = rest)
note_code  out  5  note to tone generator
tone_en  out  1  tone generator enable
playing  out  1  high in FETCH/LOAD/PLAY/GAP
paused  out  1  high in PAUSED
song_done  out  1  one-cycle pulse at song end (LOOP=0 only)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (any state, including mid-note): state IDLE, idx 0, song_q 0, note_code 0, tone_en 0, playing 0, paused 0, song_done 0, counters 0. rom_addr = {song_q, idx} = 0.
- The ROM is synchronous with 1-cycle read latency. rom_addr is driven from registered song_q and idx.
- States:
  - IDLE: play -> latch song_sel into song_q, idx = 0, go to FETCH.
  - FETCH: rom_addr is stable for one cycle -> LOAD.
  - LOAD: sample rom_data.
    - dur == 0 is the end marker. If LOOP=1 and idx != 0: idx = 0, go to FETCH. Otherwise: go to IDLE, pulse song_done for 1 cycle, and set note_code to 0.
    - dur != 0: note_code = rom_data[4:0], tone_en = (note != 0), load the counters, go to PLAY.
  - PLAY: lasts dur*TICKS_PER_UNIT - GAP_TICKS cycles. The tick counter counts to TICKS_PER_UNIT-1 and a 3-bit unit counter counts remaining units. The last unit ends early at tick TICKS_PER_UNIT-GAP_TICKS-1. Exit goes to GAP, or directly to the advance step if GAP_TICKS = 0.
  - GAP: tone_en = 0 and note_code is held for GAP_TICKS cycles, then advance.
  - Advance: idx = idx + 1 mod 32 (a table with no end marker wraps 31 -> 0), then go to FETCH.
  - PAUSED: tone_en = 0; counters, note_code and idx are frozen. play returns to the saved state (PLAY or GAP). On resume into PLAY, tone_en is restored to (note_code != 0).
- Note period: dur*TICKS_PER_UNIT + 2 cycles (FETCH + LOAD overhead).
- The play pulse has no effect in FETCH or LOAD.
- stop (any state): IDLE, idx 0, tone_en 0, note_code 0, no song_done. Simultaneous stop + play: stop wins.
- song_sel is ignored outside the IDLE start event. On a loop restart, song_q is kept.
- Simultaneous rst and any input: rst wins.

Test Plan:
1. Settings: TICKS_PER_UNIT=4, GAP_TICKS=1, LOOP=0. Song 0 = {dur2/note5, dur1/note0, end}. Play pulse at cycle 0 ->
   - FETCH at c1, LOAD at c2.
   - tone_en=1 with note_code=5 for c3-c9 (7 cycles); GAP at c10.
   - FETCH c11, LOAD c12; rest with tone_en=0 for c13-c15; GAP c16.
   - FETCH c17, LOAD c18 (end marker); song_done=1 at c19 only, then IDLE.
2. Pause/resume: in scenario 1, play at c5 (3rd PLAY cycle) -> tone_en=0, paused=1 for 10 cycles; play again -> tone_en=1 for exactly 4 more cycles, then GAP. Total PLAY cycles = 7.
3. LOOP=1, song_sel=2, end marker at idx 3 -> after LOAD of idx 3, rom_addr returns to 7'h40 and playback continues. Separately, a 32-entry table with no marker has rom_addr wrap 7'h5F -> 7'h40.
4. stop and play asserted in the same cycle mid-PLAY -> next cycle IDLE, tone_en=0, note_code=0, playing=0, song_done=0.
5. rst asserted mid-GAP and mid-PAUSED -> next cycle all outputs at reset values. A following play starts at rom_addr {song_sel, 5'd0}.
6. dur=7, GAP_TICKS=0 -> tone_en high for exactly 28 cycles, no GAP state, next FETCH immediately. Changing song_sel mid-song does not change rom_addr[6:5].

Source files
------------

// File: rtl/music_box_sequencer.sv
// Music box playback sequencer.
// Walks a song's note table in ROM and drives the tone generator.
module music_box_sequencer #(
  parameter int TICKS_PER_UNIT = 1500000,
  parameter int GAP_TICKS      = 120000,
  parameter int LOOP           = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play,
  input  logic       stop,
  input  logic [1:0] song_sel,
  output logic [6:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [4:0] note_code,
  output logic       tone_en,
  output logic       playing,
  output logic       paused,
  output logic       song_done
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, PLAY, GAP, PAUSED
  } state_t;

  localparam logic [23:0] TICK_MAX =
    24'(TICKS_PER_UNIT - 1);
  localparam logic [23:0] TICK_END =
    24'(TICKS_PER_UNIT - GAP_TICKS - 1);
  localparam bit HAS_GAP = (GAP_TICKS != 0);
  localparam bit LOOPS   = (LOOP != 0);

  state_t      state;
  logic        resume_gap;
  logic [1:0]  song_q;
  logic [4:0]  idx;
  logic [23:0] tick;
  logic [2:0]  units;
  logic        last_tick;

  assign rom_addr  = {song_q, idx};
  assign last_tick = (units == 3'd0) && (tick == TICK_END);

  // Playback FSM with note timing and registered outputs
  always_ff @(posedge clk) begin
    song_done <= 1'b0;
    if (rst) begin
      state      <= IDLE;
      resume_gap <= 1'b0;
      song_q     <= 2'd0;
      idx        <= 5'd0;
      tick       <= 24'd0;
      units      <= 3'd0;
      note_code  <= 5'd0;
      tone_en    <= 1'b0;
      playing    <= 1'b0;
      paused     <= 1'b0;
    end else if (stop) begin
      state     <= IDLE;
      idx       <= 5'd0;
      note_code <= 5'd0;
      tone_en   <= 1'b0;
      playing   <= 1'b0;
      paused    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (play) begin
            song_q  <= song_sel;
            idx     <= 5'd0;
            state   <= FETCH;
            playing <= 1'b1;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          if (rom_data[7:5] == 3'd0) begin
            if (LOOPS && idx != 5'd0) begin
              idx   <= 5'd0;
              state <= FETCH;
            end else begin
              state     <= IDLE;
              idx       <= 5'd0;
              note_code <= 5'd0;
              tone_en   <= 1'b0;
              playing   <= 1'b0;
              song_done <= !LOOPS;
            end
          end else begin
            note_code <= rom_data[4:0];
            tone_en   <= (rom_data[4:0] != 5'd0);
            tick      <= 24'd0;
            units     <= rom_data[7:5] - 3'd1;
            state     <= PLAY;
          end
        end
        PLAY: begin
          if (last_tick) begin
            tone_en <= 1'b0;
            if (!HAS_GAP) begin
              idx   <= idx + 5'd1;
              state <= FETCH;
            end else begin
              tick       <= tick + 24'd1;
              resume_gap <= 1'b1;
              if (play) begin
                state   <= PAUSED;
                playing <= 1'b0;
                paused  <= 1'b1;
              end else begin
                state <= GAP;
              end
            end
          end else begin
            if (tick == TICK_MAX) begin
              tick  <= 24'd0;
              units <= units - 3'd1;
            end else begin
              tick <= tick + 24'd1;
            end
            if (play) begin
              state      <= PAUSED;
              resume_gap <= 1'b0;
              tone_en    <= 1'b0;
              playing    <= 1'b0;
              paused     <= 1'b1;
            end
          end
        end
        GAP: begin
          if (tick == TICK_MAX) begin
            idx   <= idx + 5'd1;
            state <= FETCH;
          end else begin
            tick <= tick + 24'd1;
            if (play) begin
              state      <= PAUSED;
              resume_gap <= 1'b1;
              playing    <= 1'b0;
              paused     <= 1'b1;
            end
          end
        end
        PAUSED: begin
          if (play) begin
            state   <= resume_gap ? GAP : PLAY;
            tone_en <= !resume_gap && (note_code != 5'd0);
            playing <= 1'b1;
            paused  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_music_box_sequencer.sv
// Bench for music_box_sequencer: three parameter sets, one
// phase/countdown model, per-cycle compare plus literal checks.
module tb_music_box_sequencer;

  localparam int T = 4;
  localparam int GT [3] = '{1, 1, 0};
  localparam int LP [3] = '{0, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, play, stop;
  logic [1:0] song_sel;
  logic [6:0] ra [3];
  logic [7:0] rd [3];
  logic [4:0] nc [3];
  logic       te [3];
  logic       pl [3];
  logic       pa [3];
  logic       dn [3];
  logic [7:0] mem [128];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit armed = 1'b0;

  // model: phase 0 idle,1 fetch,2 load,3 play,4 gap,5 paused
  int ph [3], sv [3], left [3], idx [3], sq [3];
  int mnc [3], mdn [3];

  logic       te_h [3][256];
  logic       pl_h [3][256];
  logic       pa_h [3][256];
  logic       dn_h [3][256];
  logic [6:0] ra_h [3][256];
  logic [4:0] nc_h [3][256];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gen_dut
      music_box_sequencer #(
        .TICKS_PER_UNIT(T),
        .GAP_TICKS(GT[g]),
        .LOOP(LP[g])
      ) dut (
        .clk(clk),
        .rst(rst),
        .play(play),
        .stop(stop),
        .song_sel(song_sel),
        .rom_addr(ra[g]),
        .rom_data(rd[g]),
        .note_code(nc[g]),
        .tone_en(te[g]),
        .playing(pl[g]),
        .paused(pa[g]),
        .song_done(dn[g])
      );
    end
  endgenerate

  // synchronous ROMs, one read port per DUT
  always @(posedge clk)
    for (int k = 0; k < 3; k++) rd[k] <= mem[ra[k]];

  task automatic mstep(input int k);
    logic [7:0] w;
    int d;
    mdn[k] = 0;
    if (rst) begin
      ph[k] = 0; idx[k] = 0; sq[k] = 0;
      mnc[k] = 0; left[k] = 0;
    end else if (stop) begin
      ph[k] = 0; idx[k] = 0; mnc[k] = 0;
    end else begin
      case (ph[k])
        0: if (play) begin
          sq[k] = int'(song_sel); idx[k] = 0; ph[k] = 1;
        end
        1: ph[k] = 2;
        2: begin
          w = mem[7'(sq[k] * 32 + idx[k])];
          d = int'(w[7:5]);
          if (d == 0) begin
            if (LP[k] != 0 && idx[k] != 0) begin
              idx[k] = 0; ph[k] = 1;
            end else begin
              ph[k] = 0; idx[k] = 0; mnc[k] = 0;
              mdn[k] = (LP[k] == 0) ? 1 : 0;
            end
          end else begin
            mnc[k] = int'(w[4:0]);
            left[k] = d * T - GT[k];
            ph[k] = 3;
          end
        end
        3, 4: begin
          left[k] = left[k] - 1;
          if (left[k] == 0) begin
            if (ph[k] == 3 && GT[k] != 0) begin
              ph[k] = 4; left[k] = GT[k];
            end else begin
              idx[k] = (idx[k] + 1) % 32; ph[k] = 1;
            end
          end
          if (play && ph[k] >= 3) begin
            sv[k] = ph[k]; ph[k] = 5;
          end
        end
        5: if (play) ph[k] = sv[k];
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic p, input logic s,
                      input logic r, input logic [1:0] sel);
    play = p; stop = s; rst = r; song_sel = sel;
    @(posedge clk);
    for (int k = 0; k < 3; k++) mstep(k);
    cyc++;
    #1;
  endtask

  task automatic rec(input int c);
    for (int k = 0; k < 3; k++) begin
      te_h[k][c] = te[k]; pl_h[k][c] = pl[k];
      pa_h[k][c] = pa[k]; dn_h[k][c] = dn[k];
      ra_h[k][c] = ra[k]; nc_h[k][c] = nc[k];
    end
  endtask

  // cycle c-1 is the cycle in which inputs are driven
  task automatic run(input logic [1:0] sel, input int first,
                     input int last, input int p1, input int p2,
                     input int p3, input int s1, input int r1);
    for (int c = first; c <= last; c++) begin
      step(((c - 1) == p1) || ((c - 1) == p2) || ((c - 1) == p3),
           (c - 1) == s1, (c - 1) == r1, sel);
      rec(c);
    end
  endtask

  task automatic chk(input string name, input int got,
                     input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic int cnt_te(input int k, input int a,
                                input int b);
    int n = 0;
    for (int c = a; c <= b; c++) n += int'(te_h[k][c]);
    return n;
  endfunction

  function automatic int cnt_pa(input int k, input int a,
                                input int b);
    int n = 0;
    for (int c = a; c <= b; c++) n += int'(pa_h[k][c]);
    return n;
  endfunction

  function automatic int cnt_dn(input int k, input int a,
                                input int b);
    int n = 0;
    for (int c = a; c <= b; c++) n += int'(dn_h[k][c]);
    return n;
  endfunction

  // per-cycle compare of every DUT against the model
  initial forever begin
    @(negedge clk);
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        logic [6:0] ea;
        logic [4:0] en;
        logic et, ep, eq, ed;
        ea = 7'(sq[k] * 32 + idx[k]);
        en = 5'(mnc[k]);
        et = (ph[k] == 3) && (mnc[k] != 0);
        ep = (ph[k] >= 1) && (ph[k] <= 4);
        eq = (ph[k] == 5);
        ed = (mdn[k] != 0);
        vectors++;
        if ({ra[k], nc[k], te[k], pl[k], pa[k], dn[k]} !==
            {ea, en, et, ep, eq, ed}) begin
          miscompares++;
          $display("FAIL cycle%0d dut%0d got addr=%h note=%0d ten=%b pl=%b pa=%b dn=%b want addr=%h note=%0d ten=%b pl=%b pa=%b dn=%b",
                   cyc, k, ra[k], nc[k], te[k], pl[k], pa[k], dn[k],
                   ea, en, et, ep, eq, ed);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[0]  = {3'd2, 5'd5};
    mem[1]  = {3'd1, 5'd0};
    mem[32] = {3'd7, 5'd9};
    mem[33] = {3'd1, 5'd3};
    mem[64] = {3'd1, 5'd1};
    mem[65] = {3'd1, 5'd2};
    mem[66] = {3'd1, 5'd3};
    for (int i = 0; i < 32; i++) mem[96 + i] = {3'd1, 5'(i)};

    step(1'b0, 1'b0, 1'b1, 2'd0);
    armed = 1'b1;
    step(1'b0, 1'b0, 1'b1, 2'd0);
    chk("reset_addr", int'(ra[0]), 0);
    chk("reset_playing", int'(pl[0]), 0);
    chk("reset_tone", int'(te[0]), 0);
    chk("reset_note", int'(nc[1]), 0);

    // basic song, LOOP=0 on dut0
    run(2'd0, 1, 25, 0, -1, -1, -1, -1);
    chk("s1_c1_playing", int'(pl_h[0][1]), 1);
    chk("s1_c2_tone", int'(te_h[0][2]), 0);
    chk("s1_c3_note", int'(nc_h[0][3]), 5);
    chk("s1_c9_tone", int'(te_h[0][9]), 1);
    chk("s1_c10_gap_tone", int'(te_h[0][10]), 0);
    chk("s1_c10_gap_playing", int'(pl_h[0][10]), 1);
    chk("s1_tone_cycles", cnt_te(0, 1, 25), 7);
    chk("s1_c11_addr", int'(ra_h[0][11]), 1);
    chk("s1_c13_rest_tone", int'(te_h[0][13]), 0);
    chk("s1_c17_addr", int'(ra_h[0][17]), 2);
    chk("s1_c18_done", int'(dn_h[0][18]), 0);
    chk("s1_c19_done", int'(dn_h[0][19]), 1);
    chk("s1_done_count", cnt_dn(0, 1, 25), 1);
    chk("s1_c19_playing", int'(pl_h[0][19]), 0);
    step(1'b0, 1'b1, 1'b0, 2'd0);

    // pause at c5, resume at c15
    run(2'd0, 1, 25, 0, 5, 15, -1, -1);
    chk("s2_c6_paused", int'(pa_h[0][6]), 1);
    chk("s2_c6_tone", int'(te_h[0][6]), 0);
    chk("s2_paused_cycles", cnt_pa(0, 1, 25), 10);
    chk("s2_c16_tone", int'(te_h[0][16]), 1);
    chk("s2_c19_tone", int'(te_h[0][19]), 1);
    chk("s2_c20_gap_tone", int'(te_h[0][20]), 0);
    chk("s2_c20_playing", int'(pl_h[0][20]), 1);
    chk("s2_tone_cycles", cnt_te(0, 1, 25), 7);
    step(1'b0, 1'b1, 1'b0, 2'd0);

    // stop and play together mid-note
    run(2'd0, 1, 8, 0, 5, -1, 5, -1);
    chk("s4_c5_tone", int'(te_h[0][5]), 1);
    chk("s4_c6_playing", int'(pl_h[0][6]), 0);
    chk("s4_c6_tone", int'(te_h[0][6]), 0);
    chk("s4_c6_note", int'(nc_h[0][6]), 0);
    chk("s4_c6_done", int'(dn_h[0][6]), 0);

    // reset during GAP, then during PAUSED
    run(2'd0, 1, 12, 0, -1, -1, -1, 10);
    chk("s5_c10_gap", int'(pl_h[0][10]), 1);
    chk("s5_c11_playing", int'(pl_h[0][11]), 0);
    chk("s5_c11_note", int'(nc_h[0][11]), 0);
    run(2'd2, 1, 10, 0, 4, -1, -1, 8);
    chk("s5_c7_paused", int'(pa_h[0][7]), 1);
    chk("s5_c7_addr", int'(ra_h[0][7]), 'h40);
    chk("s5_c9_paused", int'(pa_h[0][9]), 0);
    chk("s5_c9_addr", int'(ra_h[0][9]), 0);
    run(2'd1, 1, 3, 0, -1, -1, -1, -1);
    chk("s5_restart_addr", int'(ra_h[0][1]), 'h20);
    step(1'b0, 1'b1, 1'b0, 2'd0);

    // long note, no gap (dut2), song_sel changed mid-song
    run(2'd1, 1, 10, 0, -1, -1, -1, -1);
    run(2'd3, 11, 40, -1, -1, -1, -1, -1);
    chk("s6_tone_cycles", cnt_te(2, 1, 31), 28);
    chk("s6_c3_tone", int'(te_h[2][3]), 1);
    chk("s6_c30_tone", int'(te_h[2][30]), 1);
    chk("s6_c31_tone", int'(te_h[2][31]), 0);
    chk("s6_c31_fetch_addr", int'(ra_h[2][31]), 'h21);
    chk("s6_c20_addr", int'(ra_h[2][20]), 'h20);
    chk("s6_c39_done", int'(dn_h[2][39]), 1);
    step(1'b0, 1'b1, 1'b0, 2'd0);

    // loop restart on dut1
    run(2'd2, 1, 30, 0, -1, -1, -1, -1);
    chk("s3_c19_addr", int'(ra_h[1][19]), 'h43);
    chk("s3_c21_addr", int'(ra_h[1][21]), 'h40);
    chk("s3_c21_playing", int'(pl_h[1][21]), 1);
    chk("s3_c23_tone", int'(te_h[1][23]), 1);
    chk("s3_noloop_done", int'(dn_h[0][21]), 1);
    step(1'b0, 1'b1, 1'b0, 2'd0);

    // 32-entry table without an end marker wraps
    run(2'd3, 1, 200, 0, -1, -1, -1, -1);
    chk("s3_wrap_c187", int'(ra_h[1][187]), 'h7F);
    chk("s3_wrap_c193", int'(ra_h[1][193]), 'h60);
    chk("s3_wrap_noloop", int'(ra_h[0][193]), 'h60);
    step(1'b0, 1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
